// File: rtl/delay_credit_fifo.sv
// delay_credit_fifo: first-word-fall-through elastic buffer placed after
// delay_chain. The top DN slots are held back as credit for words already
// in flight inside the chain, so afull warns upstream early enough that
// nothing it launched is lost. Occupancy and a sticky overflow flag are
// exported for status.
module delay_credit_fifo #(
    parameter int DW    = 64,
    parameter int DN    = 8,
    parameter int DEPTH = 16,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_vld,
    input  logic [DW-1:0] in_data,
    output logic          afull,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [DW-1:0] out_data,
    output logic [CW-1:0] count,
    output logic          ovf
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] DN_C    = CW'(DN);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          full_s, pop_s, push_s;

    // Handshake qualifiers: a pop frees the slot a same-cycle push may take when full.
    always_comb begin
        full_s = (count_q == DEPTH_C);
        pop_s  = (count_q != {CW{1'b0}}) & out_rdy;
        push_s = in_vld & (~full_s | pop_s);
    end

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1'b1);
            2'b01:   count_d = count_q - CW'(1'b1);
            default: count_d = count_q;
        endcase
        if (in_vld & full_s & ~pop_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Control state; reset takes effect immediately, even mid-transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage array; left unreset since it is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // Outputs decoded purely from registers, with no path from in_* or out_rdy.
    always_comb begin
        out_vld = (count_q != {CW{1'b0}});
        afull   = ((DEPTH_C - count_q) <= DN_C);
        count   = count_q;
        ovf     = ovf_q;
        if (out_vld) begin
            out_data = mem_q[rd_ptr_q];
        end else begin
            out_data = {DW{1'b0}};
        end
    end

endmodule

// File: tb/tb_delay_credit_fifo.sv
// Bench for delay_credit_fifo. The scoreboard is a queue of the words the
// FIFO should hold, updated from the stimulus on each rising edge using
// the push/pop/drop rules. A monitor compares every DUT output against the
// queue on each falling edge. Directed sections cover the reset, threshold,
// overflow and full-simultaneous cases; a random section covers pointer
// wrap and a mid-cycle asynchronous reset.
module tb_delay_credit_fifo;

    localparam int DW    = 64;
    localparam int DN    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_vld;
    logic [DW-1:0] in_data;
    logic          afull;
    logic          out_vld;
    logic          out_rdy;
    logic [DW-1:0] out_data;
    logic [CW-1:0] count;
    logic          ovf;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] exp_q[$];
    logic          m_ovf = 1'b0;

    delay_credit_fifo #(.DW(DW), .DN(DN), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (in_vld),
        .in_data (in_data),
        .afull   (afull),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .out_data(out_data),
        .count   (count),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO contents as a plain queue, updated at each edge.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                exp_q.delete();
                m_ovf = 1'b0;
            end else begin
                bit do_pop;
                bit was_full;
                do_pop   = (exp_q.size() != 0) && (out_rdy === 1'b1);
                was_full = (exp_q.size() == DEPTH);
                if (do_pop) void'(exp_q.pop_front());
                if (in_vld === 1'b1) begin
                    if (!was_full || do_pop) exp_q.push_back(in_data);
                    else m_ovf = 1'b1;
                end
            end
        end
    end

    // Monitor: compare all outputs against the model away from the active edge.
    initial begin
        forever begin
            int n;
            @(negedge clk);
            n = exp_q.size();
            chk("out_vld", 64'(out_vld), 64'(n != 0));
            chk("count",   64'(count),   64'(n));
            chk("afull",   64'(afull),   64'((DEPTH - n) <= DN));
            chk("ovf",     64'(ovf),     64'(m_ovf));
            chk("out_data", out_data, (n != 0) ? exp_q[0] : 64'h0);
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input logic v, input logic [63:0] d, input logic r);
        in_vld  = v;
        in_data = d;
        out_rdy = r;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        in_vld  = 1'b1;
        in_data = 64'hDEAD_BEEF;
        out_rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_vld",  64'(out_vld), 64'h0);
        chk("rst_afull",    64'(afull),   64'h0);
        chk("rst_count",    64'(count),   64'h0);
        chk("rst_ovf",      64'(ovf),     64'h0);
        chk("rst_out_data", out_data,     64'h0);
        in_vld  = 1'b0;
        out_rdy = 1'b0;
        rst_n   = 1'b1;
    endtask

    initial begin
        int words;
        rst_n   = 1'b0;
        in_vld  = 1'b0;
        in_data = 64'h0;
        out_rdy = 1'b0;
        @(negedge clk);
        do_reset();

        // Single word: one-cycle latency, then popped.
        step(1'b1, 64'h1234, 1'b0);
        chk("single_vld",   64'(out_vld), 64'h1);
        chk("single_data",  out_data,     64'h1234);
        chk("single_count", 64'(count),   64'h1);
        step(1'b0, 64'h0, 1'b1);
        chk("single_pop_vld",   64'(out_vld), 64'h0);
        chk("single_pop_count", 64'(count),   64'h0);

        // Threshold: afull at DEPTH-DN, released by one pop.
        for (int i = 1; i <= 8; i++) step(1'b1, 64'(i), 1'b0);
        chk("thr_afull_on", 64'(afull), 64'h1);
        chk("thr_count8",   64'(count), 64'h8);
        step(1'b0, 64'h0, 1'b1);
        chk("thr_afull_off", 64'(afull), 64'h0);
        chk("thr_count7",    64'(count), 64'h7);

        // Full and overflow: 17th word dropped, words 1..16 drained in order.
        do_reset();
        for (int i = 1; i <= 16; i++) step(1'b1, 64'(i), 1'b0);
        step(1'b1, 64'd17, 1'b0);
        chk("ovf_count", 64'(count), 64'd16);
        chk("ovf_flag",  64'(ovf),   64'h1);
        chk("ovf_head",  out_data,   64'd1);
        for (int i = 0; i < 18; i++) step(1'b0, 64'h0, 1'b1);
        chk("ovf_drained", 64'(count), 64'h0);
        chk("ovf_sticky",  64'(ovf),   64'h1);

        // Full simultaneous push and pop: both proceed, no overflow.
        do_reset();
        for (int i = 1; i <= 16; i++) step(1'b1, 64'(100 + i), 1'b0);
        step(1'b1, 64'hAA, 1'b1);
        chk("fsim_count", 64'(count), 64'd16);
        chk("fsim_ovf",   64'(ovf),   64'h0);
        chk("fsim_head",  out_data,   64'd102);
        for (int i = 0; i < 18; i++) step(1'b0, 64'h0, 1'b1);

        // Random stream across pointer wrap, with a mid-cycle async reset.
        do_reset();
        words = 0;
        for (int it = 0; it < 400 && words < 40; it++) begin
            logic v;
            v = 1'($urandom_range(0, 1));
            if (v) words++;
            if (it == 25) begin
                #2;
                rst_n = 1'b0;
                #1;
                chk("mid_rst_vld",   64'(out_vld), 64'h0);
                chk("mid_rst_count", 64'(count),   64'h0);
                chk("mid_rst_afull", 64'(afull),   64'h0);
                chk("mid_rst_ovf",   64'(ovf),     64'h0);
                chk("mid_rst_data",  out_data,     64'h0);
                @(negedge clk);
                rst_n = 1'b1;
            end
            step(v, {$urandom, $urandom}, 1'($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 20; i++) step(1'b0, 64'h0, 1'b1);
        chk("rand_drained", 64'(count), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/delay_credit_fifo.md
Name: delay_credit_fifo

Overview:
- Elastic buffer sitting directly downstream of delay_chain; absorbs the DN-cycle in-flight data.
- Upstream issues data into delay_chain only while afull is low. Every word already inside the chain (up to DN) is guaranteed a slot here.
- Presents a first-word-fall-through valid/ready stream to the consumer, plus occupancy and sticky overflow status.

Parameters:
- DW, 64, data width; matches delay_chain DW.
- DN, 8, delay_chain depth; also the number of slots reserved for in-flight words.
- DEPTH, 16, FIFO entries; power of two, DEPTH > DN required.
- CW, $clog2(DEPTH)+1, occupancy counter width (derived; not overridden).

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_vld, input, 1, word present on in_data this cycle (delay_chain output qualifier).
- in_data, input, DW, write data (delay_chain xo).
- afull, output, 1, free slots <= DN; upstream must stop launching.
- out_vld, output, 1, FIFO non-empty; out_data holds the head word.
- out_rdy, input, 1, consumer accepts the head word.
- out_data, output, DW, head word; 0 when empty.
- count, output, CW, current occupancy, 0..DEPTH.
- ovf, output, 1, sticky: a write was dropped because the FIFO was full.

Behaviour:
- Reset (asynchronous, immediate on rst_n low, including mid-transfer):
  - wr_ptr = rd_ptr = 0, count = 0, ovf = 0.
  - Therefore out_vld = 0, afull = 0, out_data = 0.
  - Memory contents are not reset and are never visible while empty.
- Define pop = out_vld & out_rdy.
- Define push = in_vld & (count != DEPTH | pop).
- Push: mem[wr_ptr] <= in_data; wr_ptr increments modulo DEPTH (natural wrap, log2(DEPTH) bits).
- Pop: rd_ptr increments modulo DEPTH.
- Count update:
  - +1 on push only, -1 on pop only.
  - Unchanged on both or neither.
  - Never exceeds DEPTH, never goes below 0.
- out_vld = (count != 0). out_data = mem[rd_ptr] when out_vld, else 0. Both decoded from registers only, with no combinational path from in_* or out_rdy.
- Latency: a word pushed at edge N gives out_vld = 1 and out_data = that word after edge N when the FIFO was empty (one cycle, no bypass).
- Simultaneous push and pop:
  - When empty: pop is impossible (out_vld = 0); push proceeds and count becomes 1.
  - When full: both proceed and count stays DEPTH. The popped word is the old head; the new word goes to the freed slot (wr_ptr == rd_ptr before the edge).
- Full with in_vld and no pop: word dropped, ovf <= 1. ovf is cleared only by reset. Pointers and count are unchanged.
- afull = ((DEPTH - count) <= DN), decoded from the count register. It asserts as count reaches DEPTH-DN and deasserts on the pop that takes count below that.
- out_rdy while empty: no effect.
- Ordering: strict FIFO across pointer wrap-around.

Test Plan:
- Reset check: rst_n = 0 with in_vld = 1, out_rdy = 1 -> out_vld = 0, afull = 0, count = 0, ovf = 0, out_data = 0.
- Single word: push 64'h1234 at edge 1, out_rdy = 0 -> after edge 1: out_vld = 1, out_data = 64'h1234, count = 1. Raise out_rdy -> after next edge: out_vld = 0, count = 0.
- Threshold: push 8 words, no pops -> afull = 1 after 8th edge (count = 8). One pop -> afull = 0 (count = 7).
- Full and overflow: push 16 words, then push 17th with out_rdy = 0 -> count = 16, ovf = 1. Draining returns words 1..16 in order; word 17 is absent.
- Full simultaneous: at count = 16, push 64'hAA with out_rdy = 1 -> count stays 16, head advances. 64'hAA emerges 16th in the drain sequence; ovf stays 0.
- Wrap and mid-op reset: stream 40 random words with randomised out_rdy -> output matches a reference queue exactly. Assert rst_n low mid-stream -> all outputs return to reset values immediately, without waiting for a clock edge.
